// File: rtl/gpio_ahb_ctrl_if.sv
// AHB-Lite bus bundle for the GPIO controller slave port.
interface gpio_ahb_ctrl_if;
  logic        HSEL;
  logic [11:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/gpio_ahb_ctrl.sv
// Zero-wait AHB-Lite GPIO register file: direction/data-out to the pads, 2-flop input sync,
// edge-latched interrupt. Define GPIO_INT_EN to build the interrupt block (INT_EN/POL/STAT, IRQ).
module gpio_ahb_ctrl #(
  parameter int GPIO_WIDTH = 16
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  gpio_ahb_ctrl_if.slave        ahb,
  output logic [GPIO_WIDTH-1:0] GPIO_DIR,
  output logic [GPIO_WIDTH-1:0] GPIO_WDATA,
  input  logic [GPIO_WIDTH-1:0] GPIO_RDATA,
  output logic                  GPIO_IRQ
);
  typedef logic [GPIO_WIDTH-1:0] pin_t;

  localparam logic [2:0] R_DOUT = 3'd0;
  localparam logic [2:0] R_DIR  = 3'd1;
  localparam logic [2:0] R_DIN  = 3'd2;
`ifdef GPIO_INT_EN
  localparam logic [2:0] R_IEN   = 3'd3;
  localparam logic [2:0] R_IPOL  = 3'd4;
  localparam logic [2:0] R_ISTAT = 3'd5;
`endif

  logic       ap_vld, dp_vld, dp_wr, wr_en;
  logic [2:0] dp_reg;
  pin_t       data_out, dir, sync1, sync2, wdat, rd_pin;

  // Out-of-window addresses never reach the data phase, so they read 0 and write nothing.
  assign ap_vld = ahb.HSEL & ahb.HREADY & ahb.HTRANS[1] & (ahb.HADDR[11:5] == 7'd0);
  assign wr_en  = dp_vld & dp_wr;
  assign wdat   = ahb.HWDATA[GPIO_WIDTH-1:0];

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      dp_vld <= 1'b0;
      dp_wr  <= 1'b0;
      dp_reg <= '0;
    end else begin
      dp_vld <= ap_vld;
      dp_wr  <= ahb.HWRITE;
      dp_reg <= ahb.HADDR[4:2];
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      data_out <= '0;
      dir      <= '0;
    end else if (wr_en) begin
      if (dp_reg == R_DOUT) data_out <= wdat;
      if (dp_reg == R_DIR)  dir      <= wdat;
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= GPIO_RDATA;
      sync2 <= sync1;
    end
  end

`ifdef GPIO_INT_EN
  pin_t int_en, int_pol, int_stat, prev, pin_edge, w1c;
  logic irq_q;

  for (genvar i = 0; i < GPIO_WIDTH; i++) begin : g_edge
    assign pin_edge[i] = int_pol[i] ? (sync2[i] & ~prev[i]) : (~sync2[i] & prev[i]);
  end

  assign w1c = (wr_en && dp_reg == R_ISTAT) ? wdat : '0;

  // Edge set is OR'd in after the clear so a coincident edge keeps the flag.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      int_en   <= '0;
      int_pol  <= '0;
      int_stat <= '0;
      prev     <= '0;
      irq_q    <= 1'b0;
    end else begin
      if (wr_en && dp_reg == R_IEN)  int_en  <= wdat;
      if (wr_en && dp_reg == R_IPOL) int_pol <= wdat;
      int_stat <= (int_stat & ~w1c) | pin_edge;
      prev     <= sync2;
      irq_q    <= |(int_stat & int_en);
    end
  end

  assign GPIO_IRQ = irq_q;
`else
  assign GPIO_IRQ = 1'b0;
`endif

  always_comb begin
    rd_pin = '0;
    case (dp_reg)
      R_DOUT:  rd_pin = data_out;
      R_DIR:   rd_pin = dir;
      R_DIN:   rd_pin = sync2;
`ifdef GPIO_INT_EN
      R_IEN:   rd_pin = int_en;
      R_IPOL:  rd_pin = int_pol;
      R_ISTAT: rd_pin = int_stat;
`endif
      default: rd_pin = '0;
    endcase
    ahb.HRDATA = '0;
    if (dp_vld && !dp_wr) ahb.HRDATA[GPIO_WIDTH-1:0] = rd_pin;
  end

  assign ahb.HREADYOUT = 1'b1;
  assign ahb.HRESP     = 1'b0;
  assign GPIO_DIR      = dir;
  assign GPIO_WDATA    = data_out;

  logic unused_bits;
  assign unused_bits = ^{ahb.HSIZE, ahb.HADDR[1:0], ahb.HWDATA};
endmodule

// File: tb/tb_gpio_ahb_ctrl.sv
// Self-checking bench for gpio_ahb_ctrl: directed table, timing corners, random vs reference model.
module tb_gpio_ahb_ctrl;
  localparam int          W = 16;
  localparam logic [31:0] M = 32'h0000_FFFF;

  logic         HCLK = 1'b0;
  logic         HRESETn;
  logic [W-1:0] gpio_dir, gpio_wdata, gpio_rdata;
  logic         gpio_irq;

  gpio_ahb_ctrl_if bus();

  gpio_ahb_ctrl #(.GPIO_WIDTH(W)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .ahb(bus),
    .GPIO_DIR(gpio_dir), .GPIO_WDATA(gpio_wdata), .GPIO_RDATA(gpio_rdata), .GPIO_IRQ(gpio_irq)
  );

  always #5 HCLK = ~HCLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: architectural register values plus a history of pin samples
  // (hist[0] newest edge sample, hist[1] is what DATA_IN shows, hist[2] the one before).
  logic [31:0] m_dout, m_dir, m_en, m_pol, m_stat;
  logic [31:0] m_hist [3];
  logic        m_irq;
  logic        m_dv, m_dw;
  logic [11:0] m_da;
  logic [31:0] m_dwd;

  logic [31:0] pins;
  logic        rst_n;
  logic [31:0] s_rd, s_dir, s_wdata;
  logic        s_irq;

  typedef struct {
    logic [11:0] wa;
    logic [31:0] wd;
    logic [11:0] ra;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [12];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [11:0] a);
    case (a[4:2])
      3'd0: return m_dout;
      3'd1: return m_dir;
      3'd2: return m_hist[1];
`ifdef GPIO_INT_EN
      3'd3: return m_en;
      3'd4: return m_pol;
      3'd5: return m_stat;
`endif
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_dout = 0; m_dir = 0; m_en = 0; m_pol = 0; m_stat = 0; m_irq = 0;
    for (int i = 0; i < 3; i++) m_hist[i] = 0;
    m_dv = 0; m_dw = 0; m_da = 0; m_dwd = 0;
  endtask

  // One rising clock edge in the model; v/w/a/wd/hr describe the address phase just sampled.
  task automatic model_edge(input logic v, input logic w, input logic [11:0] a,
                            input logic [31:0] wd, input logic hr);
    logic [31:0] ev;
    logic        irq_n;
    if (!rst_n) begin
      model_reset();
      return;
    end
    ev    = 0;
    irq_n = |(m_stat & m_en);
    for (int i = 0; i < W; i++)
      if (m_hist[1][i] != m_hist[2][i] && m_hist[1][i] == m_pol[i]) ev[i] = 1'b1;
    if (m_dv && m_dw) begin
      case (m_da[4:2])
        3'd0: m_dout = m_dwd & M;
        3'd1: m_dir  = m_dwd & M;
`ifdef GPIO_INT_EN
        3'd3: m_en   = m_dwd & M;
        3'd4: m_pol  = m_dwd & M;
        3'd5: m_stat = m_stat & ~(m_dwd & M);
`endif
        default: ;
      endcase
    end
`ifdef GPIO_INT_EN
    m_stat = m_stat | ev;
    m_irq  = irq_n;
`endif
    m_hist[2] = m_hist[1];
    m_hist[1] = m_hist[0];
    m_hist[0] = pins & M;
    m_dv  = v && hr && (a[11:5] == 7'd0);
    m_dw  = w;
    m_da  = a;
    m_dwd = wd;
  endtask

  // One bus cycle: check outputs at negedge, drive data phase of the previous transfer
  // and address phase of this one, then advance the model at the posedge.
  task automatic step(input logic v, input logic w, input logic [11:0] a,
                      input logic [31:0] wd, input logic hr);
    @(negedge HCLK);
    s_rd    = bus.HRDATA;
    s_dir   = {16'h0, gpio_dir};
    s_wdata = {16'h0, gpio_wdata};
    s_irq   = gpio_irq;
    check("hrdata", bus.HRDATA, (m_dv && !m_dw) ? model_read(m_da) : 32'h0);
    check("gpio_dir", {16'h0, gpio_dir}, m_dir);
    check("gpio_wdata", {16'h0, gpio_wdata}, m_dout);
    check("gpio_irq", {31'h0, gpio_irq}, {31'h0, m_irq});
    check("hready_hresp", {30'h0, bus.HREADYOUT, bus.HRESP}, 32'h2);
    HRESETn     = rst_n;
    gpio_rdata  = pins[W-1:0];
    bus.HWDATA  = m_dwd;
    bus.HSEL    = v;
    bus.HTRANS  = v ? 2'b10 : 2'b00;
    bus.HWRITE  = w;
    bus.HADDR   = a;
    bus.HREADY  = hr;
    bus.HSIZE   = 3'b010;
    @(posedge HCLK);
    model_edge(v, w, a, wd, hr);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d); step(1'b1, 1'b1, a, d, 1'b1); endtask
  task automatic rd(input logic [11:0] a); step(1'b1, 1'b0, a, 32'h0, 1'b1); endtask
  task automatic idle(); step(1'b0, 1'b0, 12'h0, 32'h0, 1'b1); endtask
  task automatic read_reg(input logic [11:0] a, output logic [31:0] v);
    rd(a); idle(); v = s_rd;
  endtask

  initial begin
    logic [31:0] v;
    logic [11:0] ra;

    tbl[0]  = '{12'h004, 32'h0000_00FF, 12'h004, 32'h0000_00FF};
    tbl[1]  = '{12'h000, 32'h0000_A5A5, 12'h000, 32'h0000_A5A5};
    tbl[2]  = '{12'h000, 32'hFFFF_5A5A, 12'h000, 32'h0000_5A5A};
    tbl[3]  = '{12'h01C, 32'hFFFF_FFFF, 12'h01C, 32'h0};
    tbl[4]  = '{12'h018, 32'h0000_1234, 12'h000, 32'h0000_5A5A};
    tbl[5]  = '{12'h020, 32'h0000_1111, 12'h000, 32'h0000_5A5A};
    tbl[6]  = '{12'h020, 32'h0000_1111, 12'h020, 32'h0};
    tbl[7]  = '{12'h008, 32'h0000_FFFF, 12'h008, 32'h0};
`ifdef GPIO_INT_EN
    tbl[8]  = '{12'h00C, 32'hFFFF_0003, 12'h00C, 32'h0000_0003};
    tbl[9]  = '{12'h010, 32'h0000_8001, 12'h010, 32'h0000_8001};
`else
    tbl[8]  = '{12'h00C, 32'hFFFF_0003, 12'h00C, 32'h0};
    tbl[9]  = '{12'h010, 32'h0000_8001, 12'h010, 32'h0};
`endif
    tbl[10] = '{12'h014, 32'h0000_FFFF, 12'h014, 32'h0};
    tbl[11] = '{12'h00C, 32'h0000_0000, 12'h00C, 32'h0};

    rst_n = 1'b0; pins = 0; HRESETn = 1'b0; gpio_rdata = '0;
    bus.HSEL = 0; bus.HADDR = 0; bus.HTRANS = 0; bus.HWRITE = 0;
    bus.HSIZE = 3'b010; bus.HWDATA = 0; bus.HREADY = 1;
    model_reset();
    repeat (2) @(posedge HCLK);

    // Reset asserted across the data phase of a DIR write discards it.
    rst_n = 1'b1; idle(); idle();
    wr(12'h004, 32'h0000_FFFF);
    rst_n = 1'b0; idle(); idle();
    rst_n = 1'b1; idle();
    for (int a = 0; a < 32; a += 4) begin
      read_reg(12'(a), v);
      check("reset_read", v, 32'h0);
    end
    check("reset_dir", s_dir, 32'h0);

    // Pipelined writes then back-to-back reads.
    wr(12'h004, 32'h0000_00FF);
    wr(12'h000, 32'h0000_A5A5);
    rd(12'h004);
    rd(12'h000);
    check("b2b_dir", s_rd, 32'h0000_00FF);
    idle();
    check("b2b_dout", s_rd, 32'h0000_A5A5);
    check("b2b_wdata_pin", s_wdata, 32'h0000_A5A5);
    idle();
    check("b2b_dir_pin", s_dir, 32'h0000_00FF);

    for (int i = 0; i < 12; i++) begin
      wr(tbl[i].wa, tbl[i].wd);
      rd(tbl[i].ra);
      idle();
      check($sformatf("tbl%0d", i), s_rd, tbl[i].exp);
    end

    // HREADY low address phase is not latched.
    step(1'b1, 1'b1, 12'h000, 32'h0000_7777, 1'b0);
    idle();
    read_reg(12'h000, v);
    check("hready_low_ignored", v, 32'h0000_5A5A);

    // DATA_IN appears two edges after the pin change.
    pins = 32'h3;
    rd(12'h008);
    rd(12'h008);
    check("din_early", s_rd, 32'h0);
    idle();
    check("din_2edge", s_rd, 32'h3);

`ifdef GPIO_INT_EN
    repeat (3) idle();
    wr(12'h010, 32'h1);
    wr(12'h00C, 32'h1);
    wr(12'h014, 32'hFFFF);
    idle(); idle();
    read_reg(12'h014, v);
    check("stat_cleared", v, 32'h0);

    pins = 32'h2;
    repeat (5) idle();
    read_reg(12'h014, v);
    check("fall_no_set", v, 32'h0);
    check("fall_no_irq", {31'h0, s_irq}, 32'h0);

    pins = 32'h3;
    idle();
    rd(12'h014);
    rd(12'h014);
    check("stat_edge2", s_rd, 32'h0);
    idle();
    check("stat_edge3", s_rd, 32'h1);
    check("irq_edge3", {31'h0, s_irq}, 32'h0);
    idle();
    check("irq_edge4", {31'h0, s_irq}, 32'h1);

    // W1C committing on the same edge a new rising edge is detected.
    pins = 32'h2;
    repeat (5) idle();
    pins = 32'h3;
    idle();
    wr(12'h014, 32'h1);
    idle();
    read_reg(12'h014, v);
    check("set_wins", v, 32'h1);
    check("set_wins_irq", {31'h0, s_irq}, 32'h1);

    wr(12'h014, 32'h1);
    idle();
    idle();
    check("w1c_irq_lag", {31'h0, s_irq}, 32'h1);
    idle();
    check("w1c_irq_drop", {31'h0, s_irq}, 32'h0);
    read_reg(12'h014, v);
    check("w1c_stat", v, 32'h0);
`endif

    for (int n = 0; n < 500; n++) begin
      ra = {7'h0, 3'($urandom), 2'b00};
      if ($urandom_range(0, 9) == 0) ra = 12'($urandom);
      if ($urandom_range(0, 5) == 0) pins = $urandom & M;
      rst_n = ($urandom_range(0, 149) != 0);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, ra, $urandom,
           $urandom_range(0, 9) != 0);
    end
    rst_n = 1'b1;
    idle(); idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/gpio_ahb_ctrl.md
# gpio_ahb_ctrl

AHB-Lite slave that owns and sequences the bidirectional GPIO pad block for the Cortex-M3 SoC. It holds the per-pin direction and output-data registers that drive the pad block's DIR/WDATA inputs. It samples the pad block's RDATA through a two-flop synchronizer and raises an edge-triggered interrupt to the NVIC. Zero-wait-state, single-master, word-access register file.

## Interface
- GPIO_WIDTH, 16: number of GPIO pins; 1..32.
- HCLK  in  1  single system clock; all state updates on rising edge.
- HRESETn  in  1  synchronous, active-low reset, sampled on HCLK rising edge.
- HSEL  in  1  slave select.
- HADDR  in  12  byte address; HADDR[4:2] selects register, HADDR[11:5] must be 0 for a hit.
- HTRANS  in  2  transfer type; NONSEQ/SEQ (HTRANS[1]=1) are valid.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  ignored; every access is treated as a 32-bit word.
- HWDATA  in  32  write data (data phase).
- HREADY  in  1  bus ready; address phase is accepted only when high.
- HREADYOUT  out  1  constant 1.
- HRESP  out  1  constant 0 (OKAY).
- HRDATA  out  32  read data (data phase).
- GPIO_DIR  out  GPIO_WIDTH  to pad DIR; 1 = output.
- GPIO_WDATA  out  GPIO_WIDTH  to pad WDATA.
- GPIO_RDATA  in  GPIO_WIDTH  from pad RDATA; asynchronous to HCLK.
- GPIO_IRQ  out  1  level interrupt, registered.

## Operation
- Register map (offset, access, reset):
  - 0x00 DATA_OUT, RW, 0: drives GPIO_WDATA.
  - 0x04 DIR, RW, 0: drives GPIO_DIR. All pins are inputs after reset.
  - 0x08 DATA_IN, RO, 0: synchronized pin value, sync2.
  - 0x0C INT_EN, RW, 0: per-pin interrupt enable.
  - 0x10 INT_POL, RW, 0: per-pin edge select; 1 = rising, 0 = falling.
  - 0x14 INT_STAT, RW1C, 0: per-pin latched edge flag.
  - 0x18, 0x1C: reserved. Read 0, write ignored.
- Bits [31:GPIO_WIDTH] of every register read 0. Writes to those bits are ignored.
- Address phase: latch valid = HSEL & HREADY & HTRANS[1], plus HWRITE and HADDR[4:2], into data-phase registers.
- Write: in the data phase, HWDATA updates the addressed register on the edge that ends the data phase. The outputs reflect the new value from the next cycle.
- Read: HRDATA is driven combinationally from the latched address during the data phase. It returns 0 when no read is in the data phase.
- Input path: sync1 <= GPIO_RDATA, sync2 <= sync1, prev <= sync2.
  - rise = sync2 & ~prev; fall = ~sync2 & prev.
  - edge[i] = INT_POL[i] ? rise[i] : fall[i].
- INT_STAT[i] sets on edge[i] regardless of INT_EN. A write of 1 clears the bit; a write of 0 has no effect.
- Simultaneous edge and W1C on the same bit: set wins, and the bit stays 1.
- GPIO_IRQ <= |(INT_STAT & INT_EN), registered.
- Reset (any cycle, including mid-transfer): all registers, synchronizers, prev, the data-phase latch and GPIO_IRQ go to 0. A transfer in flight is discarded.

## Timing
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, GPIO_DIR=0, GPIO_WDATA=0, GPIO_IRQ=0.
- Write latency: a DIR/DATA_OUT change appears on the pad outputs 1 cycle after the data-phase edge.
- Pin-to-DATA_IN latency: 2 HCLK edges. A read issued in the cycle after the 2nd edge observes the new value.
- Pin edge to INT_STAT: 3 edges. Pin edge to GPIO_IRQ: 4 edges.
- Back-to-back transfers (pipelined write then read of the same register) return the just-written value. This holds because the write commits at the end of its data phase, which is the same edge that starts the next data phase.
- An HREADY=0 address phase from another slave is not latched.

## Configuration
- GPIO_INT_EN defined: the interrupt logic (INT_EN, INT_POL, INT_STAT, prev, GPIO_IRQ) is implemented as described above.
- GPIO_INT_EN undefined:
  - The interrupt logic is removed.
  - Offsets 0x0C–0x14 read 0 and ignore writes, and GPIO_IRQ is tied to 0.
  - DATA_IN and its synchronizer remain.

## Test plan
- Reset: hold HRESETn=0 for 2 cycles mid-write of DIR=0xFFFF, then release. All registers read 0 and GPIO_DIR=0.
- Write DIR=0x00FF, DATA_OUT=0xA5A5, then read both back-to-back. Reads return 0x00FF and 0xA5A5, GPIO_WDATA=0xA5A5, and bits [31:16] read 0.
- Drive GPIO_RDATA=0x0003 asynchronously. DATA_IN reads 0x0003 starting 2 edges later, not before.
- With INT_EN=0x0001 and INT_POL=0x0001, drive pin0 0→1. INT_STAT=0x0001 after 3 edges and GPIO_IRQ=1 after 4. A falling edge on pin0 does not set it.
- Write INT_STAT=0x0001 in the same cycle a new rising edge on pin0 is detected. INT_STAT stays 1 and IRQ stays 1. A later W1C clears it and IRQ drops 1 cycle after.
- Access offset 0x1C and HADDR=0x020. Reads return 0, writes change nothing, and HRESP stays 0.
